// File: rtl/mcp_formulation_pkg.sv
// Shared types and constants for the MCP capture-side stage.
package mcp_formulation_pkg;

   typedef enum logic [1:0] {
      FSM_IDLE = 2'd0,
      FSM_FULL = 2'd1,
      FSM_ACK  = 2'd2
   } c_fsm_t;

   localparam int unsigned ACK_CNT_W = 4;

endpackage

// File: rtl/sync_ff_n.sv
// Two-flop synchroniser for a single-bit level crossing into the clk domain.
module sync_ff_n (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mcp_formulation_c.sv
// MCP capture stage: synchronises the launch valid, captures the held launch word,
// hands it to a local consumer and returns a stretched acknowledge.
module mcp_formulation_c
   import mcp_formulation_pkg::*;
#(
   parameter int unsigned W     = 32,
   parameter int unsigned ACK_W = 2
) (
   input  logic         c_clk,
   input  logic         c_rst,
   input  logic [W-1:0] sync_l_out_r,
   input  logic         sync_l_out_valid_r,
   output logic         sync_c_ack_r,
   output logic [W-1:0] c_out_r,
   output logic         c_out_valid_r,
   input  logic         c_out_ready,
   output logic         c_busy_r,
   output logic         c_err_r
);

   // Counter runs ACK_W-1 .. 0 while in ACK, giving exactly ACK_W high cycles.
   localparam logic [ACK_CNT_W-1:0] ACK_LOAD = ACK_CNT_W'(ACK_W - 1);

   c_fsm_t               state_q, state_d;
   logic [ACK_CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]         out_d;
   logic                 valid_d, ack_d, err_d;
   logic                 s2, s3, xfer_ev;

   sync_ff_n u_sync_valid (
      .clk (c_clk),
      .rst (c_rst),
      .d   (sync_l_out_valid_r),
      .q   (s2)
   );

   always_ff @(posedge c_clk or negedge c_rst) begin
      if (!c_rst) begin
         s3 <= 1'b0;
      end else begin
         s3 <= s2;
      end
   end

   assign xfer_ev = s2 & ~s3;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = c_out_r;
      valid_d = c_out_valid_r;
      ack_d   = sync_c_ack_r;
      err_d   = c_err_r;
      case (state_q)
         FSM_IDLE: begin
            if (xfer_ev) begin
               out_d   = sync_l_out_r;
               valid_d = 1'b1;
               state_d = FSM_FULL;
            end
         end
         FSM_FULL: begin
            if (xfer_ev) begin
               err_d = 1'b1;
            end
            if (c_out_valid_r && c_out_ready) begin
               valid_d = 1'b0;
               ack_d   = 1'b1;
               cnt_d   = ACK_LOAD;
               state_d = FSM_ACK;
            end
         end
         FSM_ACK: begin
            // An event on the final ACK cycle still counts as a collision.
            if (xfer_ev) begin
               err_d = 1'b1;
            end
            if (cnt_q == '0) begin
               ack_d   = 1'b0;
               state_d = FSM_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            valid_d = 1'b0;
            ack_d   = 1'b0;
            state_d = FSM_IDLE;
         end
      endcase
   end

   always_ff @(posedge c_clk or negedge c_rst) begin
      if (!c_rst) begin
         state_q       <= FSM_IDLE;
         cnt_q         <= '0;
         c_out_r       <= '0;
         c_out_valid_r <= 1'b0;
         sync_c_ack_r  <= 1'b0;
         c_busy_r      <= 1'b0;
         c_err_r       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         c_out_r       <= out_d;
         c_out_valid_r <= valid_d;
         sync_c_ack_r  <= ack_d;
         c_busy_r      <= (state_d != FSM_IDLE);
         c_err_r       <= err_d;
      end
   end

endmodule

// File: tb/tb_mcp_formulation_c.sv
// Bench for mcp_formulation_c: four instances (ACK_W = 2, 1, 4, 15) share one stimulus
// stream and are compared each cycle against a transaction-level model.
module tb_mcp_formulation_c;

   localparam int unsigned W  = 32;
   localparam int          NI = 4;

   function automatic int unsigned aw(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         2:       return 4;
         default: return 15;
      endcase
   endfunction

   logic         c_clk = 1'b0;
   logic         c_rst;
   logic [W-1:0] din;
   logic         vin;
   logic         ready;
   logic [NI-1:0] ack, ovalid, busy, err;
   logic [W-1:0] dout [NI];

   always #5 c_clk = ~c_clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mcp_formulation_c #(
         .W     (W),
         .ACK_W (aw(gi))
      ) u_dut (
         .c_clk              (c_clk),
         .c_rst              (c_rst),
         .sync_l_out_r       (din),
         .sync_l_out_valid_r (vin),
         .sync_c_ack_r       (ack[gi]),
         .c_out_r            (dout[gi]),
         .c_out_valid_r      (ovalid[gi]),
         .c_out_ready        (ready),
         .c_busy_r           (busy[gi]),
         .c_err_r            (err[gi])
      );
   end

   // Model: valid history (p1 = sampled one edge ago, ...), word held for the
   // consumer, remaining ack cycles, sticky error.
   bit           p1, p2, p3;
   bit           m_hold [NI];
   logic [W-1:0] m_data [NI];
   int           m_ack  [NI];
   bit           m_err  [NI];

   int           npass, nfail, ntot;
   int           ack_hi [NI];
   int           ack_rises;
   bit           ack_prev;
   int           hold_left;
   logic [W-1:0] rx [$];

   task automatic model_reset();
      p1 = 0; p2 = 0; p3 = 0;
      for (int i = 0; i < NI; i++) begin
         m_hold[i] = 0;
         m_data[i] = '0;
         m_ack[i]  = 0;
         m_err[i]  = 0;
      end
   endtask

   task automatic model_edge();
      bit ev;
      // A new transfer is recognised two edges after valid is first sampled.
      ev = p2 & ~p3;
      for (int i = 0; i < NI; i++) begin
         if (m_ack[i] > 0) begin
            m_ack[i]--;
            if (ev) m_err[i] = 1;
         end else if (m_hold[i]) begin
            if (ev) m_err[i] = 1;
            if (ready) begin
               m_hold[i] = 0;
               m_ack[i]  = aw(i);
            end
         end else if (ev) begin
            m_hold[i] = 1;
            m_data[i] = din;
         end
      end
      p3 = p2;
      p2 = p1;
      p1 = vin;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("valid%0d", i), W'(ovalid[i]), W'(m_hold[i]));
         chk($sformatf("data%0d", i), dout[i], m_data[i]);
         chk($sformatf("ack%0d", i), W'(ack[i]), W'(m_ack[i] > 0));
         chk($sformatf("busy%0d", i), W'(busy[i]), W'(m_hold[i] || (m_ack[i] > 0)));
         chk($sformatf("err%0d", i), W'(err[i]), W'(m_err[i]));
      end
   endtask

   task automatic step();
      @(posedge c_clk);
      if (!c_rst) model_reset();
      else model_edge();
      @(negedge c_clk);
      check_all();
      for (int i = 0; i < NI; i++) begin
         if (ack[i]) ack_hi[i]++;
      end
      if (ack[0] && !ack_prev) ack_rises++;
      ack_prev = ack[0];
      if (ovalid[0] && ready) rx.push_back(dout[0]);
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_ack_hi();
      for (int i = 0; i < NI; i++) ack_hi[i] = 0;
   endtask

   initial begin
      npass = 0; nfail = 0; ntot = 0;
      ack_rises = 0; ack_prev = 0; hold_left = 0;
      clear_ack_hi();
      c_rst = 1'b0; vin = 1'b0; din = '0; ready = 1'b1;
      model_reset();
      wait_n(3);
      c_rst = 1'b1;
      chk("rst_valid", W'(ovalid[0]), '0);
      chk("rst_ack", W'(ack[0]), '0);
      chk("rst_data", dout[0], '0);

      // Basic transfer: capture visible 3 edges after first sample.
      clear_ack_hi();
      din = 32'hDEADBEEF; vin = 1'b1;
      step();                      // edge k
      step();                      // edge k+1
      vin = 1'b0;
      step();                      // edge k+2
      chk("basic_data", dout[0], 32'hDEADBEEF);
      chk("basic_valid", W'(ovalid[0]), W'(1));
      step();                      // edge k+3
      chk("basic_accept", W'(ovalid[0]), W'(0));
      chk("basic_ack_on", W'(ack[0]), W'(1));
      wait_n(20);
      for (int i = 0; i < NI; i++) chk($sformatf("ack_width%0d", i), W'(ack_hi[i]), W'(aw(i)));
      chk("basic_err", W'(err[0]), W'(0));

      // Backpressure.
      ready = 1'b0;
      din = 32'h12345678; vin = 1'b1;
      step();
      vin = 1'b0;
      wait_n(2);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("bp_data", dout[0], 32'h12345678);
         chk("bp_valid", W'(ovalid[0]), W'(1));
         chk("bp_noack", W'(ack[0]), W'(0));
      end
      ready = 1'b1;
      step();
      chk("bp_ack", W'(ack[0]), W'(1));
      wait_n(20);

      // Back-to-back transfers, each after the previous ack.
      rx.delete();
      ack_rises = 0;
      for (int v = 1; v <= 3; v++) begin
         din = W'(v); vin = 1'b1;
         step();
         vin = 1'b0;
         wait_n(22);
      end
      chk("b2b_count", W'(rx.size()), W'(3));
      for (int v = 0; v < 3 && v < rx.size(); v++) chk("b2b_order", rx[v], W'(v + 1));
      chk("b2b_acks", W'(ack_rises), W'(3));
      chk("b2b_err", W'(err[0]), W'(0));

      // Collision while FULL.
      ready = 1'b0;
      din = 32'h11110000; vin = 1'b1;
      step();
      vin = 1'b0;
      wait_n(4);
      din = 32'hAAAA5555; vin = 1'b1;
      step();
      vin = 1'b0;
      wait_n(4);
      chk("viol_data", dout[0], 32'h11110000);
      chk("viol_err", W'(err[0]), W'(1));
      ready = 1'b1;
      wait_n(22);
      din = 32'h00000005; vin = 1'b1;
      step();
      vin = 1'b0;
      wait_n(22);
      chk("viol_sticky", W'(err[0]), W'(1));

      // Asynchronous reset during ACK.
      din = 32'h0BADF00D; vin = 1'b1;
      step();
      vin = 1'b0;
      wait_n(4);
      chk("mid_ack", W'(ack[0]), W'(1));
      #2 c_rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("arst_ack%0d", i), W'(ack[i]), '0);
         chk($sformatf("arst_valid%0d", i), W'(ovalid[i]), '0);
         chk($sformatf("arst_busy%0d", i), W'(busy[i]), '0);
         chk($sformatf("arst_err%0d", i), W'(err[i]), '0);
         chk($sformatf("arst_data%0d", i), dout[i], '0);
      end
      model_reset();
      wait_n(2);
      c_rst = 1'b1;
      ready = 1'b0;
      clear_ack_hi();
      din = 32'hCAFEF00D; vin = 1'b1;
      step();
      vin = 1'b0;
      wait_n(4);
      chk("post_data", dout[0], 32'hCAFEF00D);
      chk("post_valid", W'(ovalid[0]), W'(1));
      ready = 1'b1;
      wait_n(22);
      chk("post_ack_width", W'(ack_hi[0]), W'(2));

      // Randomised pulses and backpressure.
      for (int n = 0; n < 500; n++) begin
         ready = ($urandom_range(0, 3) != 0);
         if (vin) begin
            hold_left--;
            if (hold_left == 0) vin = 1'b0;
         end else if ($urandom_range(0, 11) == 0) begin
            din = $urandom;
            vin = 1'b1;
            hold_left = $urandom_range(1, 3);
         end
         step();
      end
      vin = 1'b0;
      wait_n(25);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
